// File: rtl/snake_body.sv
// Snake body: advances the head once per game tick, shifts the segment register,
// detects wall/self collisions and answers renderer occupancy queries.
// Optional macro SNAKE_WRAP_EN: walls wrap instead of ending the game.
module snake_body #(
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     current_heading,
    input  logic [31:0]                    length,
    input  logic [$clog2(GRID_W)-1:0]      query_x,
    input  logic [$clog2(GRID_H)-1:0]      query_y,
    output logic                           query_hit,
    output logic                           query_head,
    output logic [$clog2(GRID_W)-1:0]      head_x,
    output logic [$clog2(GRID_H)-1:0]      head_y,
    output logic [$clog2(MAX_LEN+1)-1:0]   seg_count,
    output logic                           step,
    output logic                           game_over
);

    localparam int unsigned XW    = $clog2(GRID_W);
    localparam int unsigned YW    = $clog2(GRID_H);
    localparam int unsigned CW    = $clog2(MAX_LEN + 1);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_t;

    state_t state, state_d;

    logic [XW-1:0]    seg_x [MAX_LEN];
    logic [YW-1:0]    seg_y [MAX_LEN];
    logic [CNT_W-1:0] cnt;

    logic          tick_c;
    logic          valid_c;
    logic          wall_c;
    logic          self_c;
    logic          move_c;
    logic [XW:0]   nx_w;
    logic [YW:0]   ny_w;
    logic [XW-1:0] nx_c;
    logic [YW-1:0] ny_c;
    logic [CW-1:0] eff_len_c;
    logic          hit_c;
    logic          head_hit_c;

    assign tick_c = (cnt == CNT_W'(TICK_DIV - 1));
    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

    // Clamp requested length into 1..MAX_LEN
    always_comb begin
        eff_len_c = CW'(length);
        if (length == 32'd0) begin
            eff_len_c = CW'(1);
        end else if (length > 32'(MAX_LEN)) begin
            eff_len_c = CW'(MAX_LEN);
        end
    end

    // Candidate head, one bit wider so over/underflow shows up as out of range
    always_comb begin
        valid_c = 1'b1;
        nx_w    = {1'b0, seg_x[0]};
        ny_w    = {1'b0, seg_y[0]};
        case (current_heading)
            4'b0001: ny_w = ny_w - (YW+1)'(1);
            4'b0010: nx_w = nx_w + (XW+1)'(1);
            4'b0100: ny_w = ny_w + (YW+1)'(1);
            4'b1000: nx_w = nx_w - (XW+1)'(1);
            default: valid_c = 1'b0;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    // Overflow lands exactly on GRID_x; anything else out of range is an underflow
    always_comb begin
        wall_c = 1'b0;
        nx_c   = nx_w[XW-1:0];
        ny_c   = ny_w[YW-1:0];
        if (nx_w == (XW+1)'(GRID_W)) begin
            nx_c = '0;
        end else if (nx_w > (XW+1)'(GRID_W)) begin
            nx_c = XW'(GRID_W - 1);
        end
        if (ny_w == (YW+1)'(GRID_H)) begin
            ny_c = '0;
        end else if (ny_w > (YW+1)'(GRID_H)) begin
            ny_c = YW'(GRID_H - 1);
        end
    end
`else
    always_comb begin
        nx_c   = nx_w[XW-1:0];
        ny_c   = ny_w[YW-1:0];
        wall_c = (nx_w >= (XW+1)'(GRID_W)) || (ny_w >= (YW+1)'(GRID_H));
    end
`endif

    // Self hit against segments 1..eff_len-2; the vacating tail is excluded
    always_comb begin
        self_c = 1'b0;
        for (int i = 1; i < int'(MAX_LEN); i++) begin
            if ((i + 2 <= int'(eff_len_c)) && (seg_x[i] == nx_c) && (seg_y[i] == ny_c)) begin
                self_c = 1'b1;
            end
        end
    end

    // Renderer occupancy over the live segments
    always_comb begin
        hit_c      = 1'b0;
        head_hit_c = (seg_x[0] == query_x) && (seg_y[0] == query_y);
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if ((i < int'(seg_count)) && (seg_x[i] == query_x) && (seg_y[i] == query_y)) begin
                hit_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        move_c  = 1'b0;
        case (state)
            RUN: begin
                if (tick_c && valid_c) begin
                    if (wall_c || self_c) begin
                        state_d = OVER;
                    end else begin
                        move_c = 1'b1;
                    end
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            step       <= 1'b0;
            game_over  <= 1'b0;
            query_hit  <= 1'b0;
            query_head <= 1'b0;
            seg_count  <= CW'(1);
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x[i] <= XW'(GRID_W / 2);
                seg_y[i] <= YW'(GRID_H / 2);
            end
        end else begin
            cnt        <= tick_c ? '0 : cnt + CNT_W'(1);
            step       <= move_c;
            game_over  <= (state_d == OVER);
            query_hit  <= hit_c;
            query_head <= head_hit_c;
            if (move_c) begin
                seg_count <= eff_len_c;
                seg_x[0]  <= nx_c;
                seg_y[0]  <= ny_c;
                for (int i = 1; i < int'(MAX_LEN); i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
            end
        end
    end

endmodule
